// File: rtl/hex_display_scan_ctrl_if.sv
// Byte-input handshake into the hex display scanner: strict valid/ready.
// A byte transfers on a rising edge where data_valid && data_ready; clear is a one-cycle request.
interface hex_display_scan_ctrl_if;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic       clear;

   modport master (output data_in, output data_valid, output clear, input data_ready);
   modport slave  (input data_in, input data_valid, input clear, output data_ready);
endinterface

// File: rtl/hex_display_scan_ctrl.sv
// Shares one external registered hex-to-7-segment decoder across NUM_DIGITS digits,
// scanning a nibble history buffer into per-digit segment registers (3 clocks per digit).
module hex_display_scan_ctrl #(
   parameter int NUM_DIGITS = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   hex_display_scan_ctrl_if.slave    bus,
   output logic [3:0]                nib_out,
   input  logic [6:0]                seg_in,
   output logic [7*NUM_DIGITS-1:0]   hex_out,
   output logic                      busy,
   output logic [1:0]                dbg_state
);
   localparam int IDXW = $clog2(NUM_DIGITS);

   typedef enum logic [1:0] {S_IDLE, S_SET, S_WAIT, S_CAP} state_e;

   state_e                    state_q, state_d;
   logic [IDXW-1:0]           idx_q, idx_d;
   logic [3:0]                nib_q, nib_d;
   logic [3:0]                nbuf_q [NUM_DIGITS];
   logic [3:0]                nbuf_d [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]     vld_q, vld_d;
   logic                      clr_pend_q, clr_pend_d;
   logic [7*NUM_DIGITS-1:0]   hex_q, hex_d;
   logic                      last_digit;

   assign bus.data_ready = (state_q == S_IDLE) && !bus.clear;
   assign last_digit     = (idx_q == IDXW'(NUM_DIGITS - 1));
   assign nib_out        = nib_q;
   assign hex_out        = hex_q;
   assign busy           = (state_q != S_IDLE);
   assign dbg_state      = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      nib_d      = nib_q;
      nbuf_d     = nbuf_q;
      vld_d      = vld_q;
      clr_pend_d = clr_pend_q;
      hex_d      = hex_q;
      // A clear seen mid-scan is deferred so the running scan stays coherent.
      if (state_q != S_IDLE && bus.clear) clr_pend_d = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (bus.clear) begin
               for (int i = 0; i < NUM_DIGITS; i++) nbuf_d[i] = 4'h0;
               vld_d   = '0;
               idx_d   = '0;
               state_d = S_SET;
            end else if (bus.data_valid) begin
               for (int i = NUM_DIGITS - 1; i >= 2; i--) begin
                  nbuf_d[i] = nbuf_q[i-2];
                  vld_d[i]  = vld_q[i-2];
               end
               nbuf_d[1] = bus.data_in[7:4];
               nbuf_d[0] = bus.data_in[3:0];
               vld_d[1]  = 1'b1;
               vld_d[0]  = 1'b1;
               idx_d     = '0;
               state_d   = S_SET;
            end
         end
         S_SET: begin
            nib_d   = nbuf_q[idx_q];
            state_d = S_WAIT;
         end
         S_WAIT: state_d = S_CAP;
         S_CAP: begin
            hex_d[7*idx_q +: 7] = vld_q[idx_q] ? seg_in : 7'h7F;
            if (!last_digit) begin
               idx_d   = idx_q + 1'b1;
               state_d = S_SET;
            end else if (clr_pend_q || bus.clear) begin
               for (int i = 0; i < NUM_DIGITS; i++) nbuf_d[i] = 4'h0;
               vld_d      = '0;
               clr_pend_d = 1'b0;
               idx_d      = '0;
               state_d    = S_SET;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q      <= '0;
         nib_q      <= 4'h0;
         vld_q      <= '0;
         clr_pend_q <= 1'b0;
         hex_q      <= '1;
         for (int i = 0; i < NUM_DIGITS; i++) nbuf_q[i] <= 4'h0;
      end else begin
         idx_q      <= idx_d;
         nib_q      <= nib_d;
         vld_q      <= vld_d;
         clr_pend_q <= clr_pend_d;
         hex_q      <= hex_d;
         for (int i = 0; i < NUM_DIGITS; i++) nbuf_q[i] <= nbuf_d[i];
      end
   end
endmodule

// File: tb/tb_hex_display_scan_ctrl.sv
// Bench for hex_display_scan_ctrl: external decoder model, byte-history reference model,
// cycle-accurate checks of nib_out/hex_out/busy/data_ready over every scan.
module tb_hex_display_scan_ctrl;
   localparam int N    = 6;
   localparam int SCAN = 3 * N;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       nib_out;
   logic [6:0]       seg_in;
   logic [7*N-1:0]   hex_out;
   logic             busy;
   logic [1:0]       dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] bytes_q[$];
   logic [6:0] m_disp   [N];
   logic [6:0] exp_disp [N];

   hex_display_scan_ctrl_if bus();

   hex_display_scan_ctrl #(.NUM_DIGITS(N)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave), .nib_out(nib_out), .seg_in(seg_in),
      .hex_out(hex_out), .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // External registered decoder: seg_in is valid one clock after nib_out is sampled.
   always @(posedge clk) seg_in <= seg7(nib_out);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Digit i shows nibble (i%2) of the (i/2)-th most recent byte, if that byte exists.
   function automatic logic [3:0] model_nib(input int i);
      logic [7:0] b;
      if (i / 2 >= bytes_q.size()) return 4'h0;
      b = bytes_q[i/2];
      return (i % 2 == 1) ? b[7:4] : b[3:0];
   endfunction

   function automatic logic [6:0] model_digit(input int i);
      if (i / 2 >= bytes_q.size()) return 7'h7F;
      return seg7(model_nib(i));
   endfunction

   function automatic logic [7*N-1:0] pack_disp();
      logic [7*N-1:0] r;
      for (int i = 0; i < N; i++) r[7*i +: 7] = m_disp[i];
      return r;
   endfunction

   task automatic model_push(input logic [7:0] b);
      bytes_q.push_front(b);
      if (bytes_q.size() > N / 2) void'(bytes_q.pop_back());
   endtask

   task automatic prep_scan();
      for (int i = 0; i < N; i++) exp_disp[i] = model_digit(i);
   endtask

   task automatic run_scan(input int clr_at, output bit pend);
      pend = 1'b0;
      for (int k = 1; k <= SCAN; k++) begin
         step();
         bus.clear = 1'b0;
         if (k % 3 == 1) check("nib_out", 64'(nib_out), 64'(model_nib((k - 1) / 3)));
         if (k % 3 == 0) begin
            m_disp[k/3-1] = exp_disp[k/3-1];
            check("hex_out", 64'(hex_out), 64'(pack_disp()));
         end
         check("busy", 64'(busy), 64'((k < SCAN) || pend));
         check("data_ready", 64'(bus.data_ready), 64'(!((k < SCAN) || pend)));
         if (k == clr_at) begin
            bus.clear = 1'b1;
            pend      = 1'b1;
         end
      end
   endtask

   task automatic scan_all(input int clr_at);
      bit p;
      prep_scan();
      run_scan(clr_at, p);
      while (p) begin
         bytes_q.delete();
         prep_scan();
         run_scan(-1, p);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int clr_at);
      int w = 0;
      while (!bus.data_ready && w < 100) begin
         step();
         w++;
      end
      check("ready_wait", 64'(bus.data_ready), 64'd1);
      bus.data_valid = 1'b1;
      bus.data_in    = b;
      step();
      bus.data_valid = 1'b0;
      model_push(b);
      check("busy_e0", 64'(busy), 64'd1);
      check("ready_e0", 64'(bus.data_ready), 64'd0);
      scan_all(clr_at);
   endtask

   task automatic clear_idle(input bit with_valid);
      bus.clear      = 1'b1;
      bus.data_valid = with_valid;
      bus.data_in    = 8'hFF;
      #1;
      check("ready_clr", 64'(bus.data_ready), 64'd0);
      step();
      bus.clear      = 1'b0;
      bus.data_valid = 1'b0;
      bytes_q.delete();
      check("busy_clr", 64'(busy), 64'd1);
      scan_all(-1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      check("rst_hex", 64'(hex_out), 64'({7*N{1'b1}}));
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ready", 64'(bus.data_ready), 64'd1);
      check("rst_nib", 64'(nib_out), 64'd0);
      rst = 1'b0;
      bytes_q.delete();
      for (int i = 0; i < N; i++) m_disp[i] = 7'h7F;
   endtask

   initial begin
      bus.data_in    = 8'h00;
      bus.data_valid = 1'b0;
      bus.clear      = 1'b0;
      rst            = 1'b1;
      do_reset();

      send_byte(8'hA5, -1);
      check("a5_lo", 64'(hex_out[13:0]), 64'({7'b0001000, 7'b0010010}));
      check("a5_blank", 64'(hex_out[41:14]), 64'({28{1'b1}}));
      send_byte(8'h3C, -1);
      check("3c", 64'(hex_out[27:0]), 64'({7'b0001000, 7'b0010010, 7'b0110000, 7'b1000110}));

      do_reset();
      send_byte(8'h00, -1);
      check("zero", 64'(hex_out), 64'({{28{1'b1}}, 7'b1000000, 7'b1000000}));

      do_reset();
      send_byte(8'h12, -1);
      send_byte(8'h34, -1);
      send_byte(8'h56, -1);
      send_byte(8'h78, -1);
      check("overflow", 64'(hex_out), 64'({7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));

      do_reset();
      send_byte(8'hA5, 5);
      check("pend_clr", 64'(hex_out), 64'({7*N{1'b1}}));

      send_byte(8'h3C, -1);
      clear_idle(1'b1);
      check("idle_clr", 64'(hex_out), 64'({7*N{1'b1}}));

      bus.data_valid = 1'b1;
      bus.data_in    = 8'h9E;
      step();
      bus.data_valid = 1'b0;
      repeat (4) step();
      #2 rst = 1'b1;
      #1;
      check("arst_hex", 64'(hex_out), 64'({7*N{1'b1}}));
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_ready", 64'(bus.data_ready), 64'd1);
      check("arst_nib", 64'(nib_out), 64'd0);
      do_reset();

      for (int it = 0; it < 24; it++) begin
         int clr_at;
         clr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, SCAN - 1)) : -1;
         if ($urandom_range(0, 7) == 0) clear_idle(1'($urandom_range(0, 1)));
         else send_byte(8'($urandom_range(0, 255)), clr_at);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
